// File: rtl/byte_unstriping_n.sv
// byte_unstriping_n
// Merges LANES striped byte lanes back into one serial stream in strict
// round-robin lane order. Each lane has its own DEPTH-entry FIFO to absorb
// skew. The output is a registered ready/valid stage.
// Optional dropped-byte counter: define BYTE_UNSTRIPING_DROP_CNT_EN.
module byte_unstriping_n #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                                       clk_8f,
    input  logic                                       rst,
    input  logic [LANES*WIDTH-1:0]                     data_stripe,
    input  logic [LANES-1:0]                           valid_stripe,
    output logic [LANES-1:0]                           ready_stripe,
    output logic [WIDTH-1:0]                           data_unstripe,
    output logic                                       valid_unstripe,
    input  logic                                       ready_unstripe,
    output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] lane_cur,
    output logic [CNT_W-1:0]                           drop_count
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LW-1:0]    r_lane_cur;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic [WIDTH-1:0] w_head [LANES];
    logic [LANES-1:0] w_nonempty;
    logic             w_out_free;
    logic             w_load;
    logic [LW-1:0]    w_lane_next;

    // The output register can take a new byte when empty or being consumed;
    // it only loads when the lane whose turn it is has data.
    assign w_out_free  = !r_valid || ready_unstripe;
    assign w_load      = w_out_free && w_nonempty[r_lane_cur];
    assign w_lane_next = (r_lane_cur == LW'(LANES - 1)) ? '0 : r_lane_cur + 1'b1;

    // Per-lane FIFOs
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_wptr;
        logic [AW-1:0]    r_rptr;
        logic [CW-1:0]    r_count;
        logic             w_push;
        logic             w_pop;

        // Ready is conservative: a full FIFO refuses even if it pops this cycle.
        assign ready_stripe[gi] = (r_count < CW'(DEPTH)) && !rst;
        assign w_push           = valid_stripe[gi] && ready_stripe[gi];
        assign w_pop            = w_load && (r_lane_cur == LW'(gi));
        assign w_nonempty[gi]   = (r_count != '0);
        assign w_head[gi]       = r_mem[r_rptr];

        // Storage array: writes only, no reset needed on contents
        always_ff @(posedge clk_8f) begin
            if (w_push) begin
                r_mem[r_wptr] <= data_stripe[gi*WIDTH +: WIDTH];
            end
        end

        // Pointer and occupancy bookkeeping
        always_ff @(posedge clk_8f) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Output register and round-robin lane pointer
    always_ff @(posedge clk_8f) begin
        if (rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_lane_cur <= '0;
        end else if (w_load) begin
            r_data     <= w_head[r_lane_cur];
            r_valid    <= 1'b1;
            r_lane_cur <= w_lane_next;
        end else if (w_out_free) begin
            // Stall on an empty current lane: byte consumed, nothing to replace it
            r_valid    <= 1'b0;
        end
    end

    assign data_unstripe  = r_data;
    assign valid_unstripe = r_valid;
    assign lane_cur       = r_lane_cur;

`ifdef BYTE_UNSTRIPING_DROP_CNT_EN
    localparam int IW = $clog2(LANES + 1);
    localparam int SW = ((CNT_W > IW) ? CNT_W : IW) + 1;

    logic [IW-1:0]    w_drop_inc;
    logic [SW-1:0]    w_drop_sum;
    logic [CNT_W-1:0] r_drop_count;

    // Number of lanes offering a byte that their FIFO refuses this cycle
    always_comb begin
        w_drop_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            w_drop_inc = w_drop_inc + IW'(valid_stripe[i] & ~ready_stripe[i]);
        end
    end

    assign w_drop_sum = SW'(r_drop_count) + SW'(w_drop_inc);

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk_8f) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop_sum > SW'({CNT_W{1'b1}})) begin
            r_drop_count <= '1;
        end else begin
            r_drop_count <= w_drop_sum[CNT_W-1:0];
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_byte_unstriping_n.sv
// Testbench for byte_unstriping_n: directed scenarios plus a randomized run,
// checked against a queue-based reference model of the lane merge.
module tb_byte_unstriping_n;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = 2;

    logic                   clk_8f;
    logic                   rst;
    logic [LANES*WIDTH-1:0] data_stripe;
    logic [LANES-1:0]       valid_stripe;
    logic [LANES-1:0]       ready_stripe;
    logic [WIDTH-1:0]       data_unstripe;
    logic                   valid_unstripe;
    logic                   ready_unstripe;
    logic [LW-1:0]          lane_cur;
    logic [CNT_W-1:0]       drop_count;

    byte_unstriping_n #(
        .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk_8f        (clk_8f),
        .rst           (rst),
        .data_stripe   (data_stripe),
        .valid_stripe  (valid_stripe),
        .ready_stripe  (ready_stripe),
        .data_unstripe (data_unstripe),
        .valid_unstripe(valid_unstripe),
        .ready_unstripe(ready_unstripe),
        .lane_cur      (lane_cur),
        .drop_count    (drop_count)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per lane plus the output register contents
    logic [WIDTH-1:0] mq [LANES][$];
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_lane  = 0;
    int               m_drop  = 0;
    logic [LANES-1:0] m_ready_pre;
    logic [LANES-1:0] obs_ready;

    // Drive one cycle of inputs, sample ready before the edge, advance the model
    task automatic tick(input logic r, input logic [LANES-1:0] v,
                        input logic [LANES*WIDTH-1:0] d, input logic ru);
        logic [LANES-1:0] acc;
        logic             free;
        rst = r; valid_stripe = v; data_stripe = d; ready_unstripe = ru;
        for (int i = 0; i < LANES; i++)
            m_ready_pre[i] = !r && (mq[i].size() < DEPTH);
        @(negedge clk_8f);
        obs_ready = ready_stripe;
        @(posedge clk_8f);
        if (r) begin
            for (int i = 0; i < LANES; i++) mq[i].delete();
            m_valid = 1'b0; m_data = '0; m_lane = 0; m_drop = 0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] = v[i] && (mq[i].size() < DEPTH);
`ifdef BYTE_UNSTRIPING_DROP_CNT_EN
                if (v[i] && !acc[i] && m_drop < (1 << CNT_W) - 1) m_drop++;
`endif
            end
            free = !m_valid || ru;
            if (free && mq[m_lane].size() > 0) begin
                m_data  = mq[m_lane].pop_front();
                m_valid = 1'b1;
                m_lane  = (m_lane + 1) % LANES;
            end else if (free) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < LANES; i++)
                if (acc[i]) mq[i].push_back(d[i*WIDTH +: WIDTH]);
        end
        #1;
    endtask

    function automatic logic [LANES*WIDTH-1:0] rand_data();
        logic [LANES*WIDTH-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return d;
    endfunction

    task automatic test_reset();
        tick(1'b1, 4'b1111, rand_data(), 1'b1);
        checks++;
        if (obs_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready_in_rst: got %b expected 0000", obs_ready);
        end
        tick(1'b1, 4'b1111, rand_data(), 1'b1);
        checks++;
        if (valid_unstripe !== 1'b0 || data_unstripe !== 8'h00 || lane_cur !== 2'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h lane=%0d drop=%0d expected all 0",
                     valid_unstripe, data_unstripe, lane_cur, drop_count);
        end
        tick(1'b0, 4'b0000, '0, 1'b1);
        checks++;
        if (obs_ready !== 4'b1111) begin
            errors++; $display("FAIL reset_ready_release: got %b expected 1111", obs_ready);
        end
        $display("test_reset: valid=%b lane=%0d ready=%b", valid_unstripe, lane_cur, obs_ready);
    endtask

    task automatic test_ordered_merge();
        logic [WIDTH-1:0] exp_b;
        tick(1'b0, 4'b1111, 32'hA3A2A1A0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            tick(1'b0, 4'b0000, '0, 1'b1);
            exp_b = 8'hA0 + 8'(j);
            checks++;
            if (valid_unstripe !== 1'b1 || data_unstripe !== exp_b || lane_cur !== 2'((j + 1) % 4)) begin
                errors++;
                $display("FAIL merge_%0d: got valid=%b data=%h lane=%0d expected 1 %h %0d",
                         j, valid_unstripe, data_unstripe, lane_cur, exp_b, (j + 1) % 4);
            end
            $display("merge cycle %0d: data=%h lane_cur=%0d", j, data_unstripe, lane_cur);
        end
        tick(1'b0, 4'b0000, '0, 1'b1);
        checks++;
        if (valid_unstripe !== 1'b0) begin
            errors++; $display("FAIL merge_end_valid: got %b expected 0", valid_unstripe);
        end
    endtask

    task automatic test_skew();
        logic [WIDTH-1:0] seq[$];
        logic [WIDTH-1:0] exp_b;
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      tick(1'b0, 4'b1011, 32'h00A1_A100 | 32'hA300_00A0, 1'b1);
            else if (c == 3) tick(1'b0, 4'b0100, 32'h00A2_0000, 1'b1);
            else             tick(1'b0, 4'b0000, '0, 1'b1);
            checks++;
            if (valid_unstripe !== m_valid || data_unstripe !== m_data || lane_cur !== LW'(m_lane)) begin
                errors++;
                $display("FAIL skew_cycle_%0d: got v=%b d=%h l=%0d expected v=%b d=%h l=%0d",
                         c, valid_unstripe, data_unstripe, lane_cur, m_valid, m_data, m_lane);
            end
            if (c == 3) begin
                checks++;
                if (valid_unstripe !== 1'b0) begin
                    errors++; $display("FAIL skew_stall: got valid=%b expected 0", valid_unstripe);
                end
            end
            if (valid_unstripe === 1'b1) seq.push_back(data_unstripe);
            $display("skew cycle %0d: valid=%b data=%h", c, valid_unstripe, data_unstripe);
        end
        checks++;
        if (seq.size() != 4) begin
            errors++; $display("FAIL skew_count: got %0d bytes expected 4", seq.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                exp_b = 8'hA0 + 8'(j);
                checks++;
                if (seq[j] !== exp_b) begin
                    errors++; $display("FAIL skew_order_%0d: got %h expected %h", j, seq[j], exp_b);
                end
            end
        end
    endtask

    task automatic test_backpressure_overflow();
        logic [WIDTH-1:0] held;
        int               drop_before;
        int               consumed;
        tick(1'b1, 4'b0000, '0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 4'b1111, rand_data(), 1'b0);
            checks++;
            if (obs_ready !== m_ready_pre || valid_unstripe !== m_valid || data_unstripe !== m_data) begin
                errors++;
                $display("FAIL bp_cycle_%0d: got rdy=%b v=%b d=%h expected rdy=%b v=%b d=%h",
                         c, obs_ready, valid_unstripe, data_unstripe, m_ready_pre, m_valid, m_data);
            end
            $display("backpressure cycle %0d: ready_stripe=%b data=%h", c, obs_ready, data_unstripe);
        end
        held        = data_unstripe;
        drop_before = int'(drop_count);
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 4'b1111, rand_data(), 1'b0);
            checks++;
            if (obs_ready !== 4'b0000 || data_unstripe !== held || valid_unstripe !== 1'b1) begin
                errors++;
                $display("FAIL overflow_cycle_%0d: got rdy=%b d=%h v=%b expected 0000 %h 1",
                         c, obs_ready, data_unstripe, valid_unstripe, held);
            end
            $display("overflow cycle %0d: drop_count=%0d", c, drop_count);
        end
        checks++;
`ifdef BYTE_UNSTRIPING_DROP_CNT_EN
        if (int'(drop_count) !== drop_before + 12 || int'(drop_count) !== m_drop) begin
            errors++; $display("FAIL overflow_drops: got %0d expected %0d", drop_count, drop_before + 12);
        end
`else
        if (drop_count !== 8'd0 || drop_before != 0) begin
            errors++; $display("FAIL overflow_drops_off: got %0d expected 0", drop_count);
        end
`endif
        consumed = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_unstripe === 1'b1) consumed++;
            tick(1'b0, 4'b0000, '0, 1'b1);
            checks++;
            if (valid_unstripe !== m_valid || data_unstripe !== m_data || lane_cur !== LW'(m_lane)) begin
                errors++;
                $display("FAIL drain_cycle_%0d: got v=%b d=%h l=%0d expected v=%b d=%h l=%0d",
                         c, valid_unstripe, data_unstripe, lane_cur, m_valid, m_data, m_lane);
            end
        end
        // lane 0 accepted 5 (one went straight to the output register), others 4
        checks++;
        if (consumed != 17) begin
            errors++; $display("FAIL drain_count: got %0d bytes expected 17", consumed);
        end
        $display("drain: consumed=%0d", consumed);
    endtask

    task automatic test_reset_midstream();
        tick(1'b0, 4'b1111, rand_data(), 1'b0);
        tick(1'b0, 4'b1111, rand_data(), 1'b0);
        tick(1'b1, 4'b1111, rand_data(), 1'b1);
        checks++;
        if (valid_unstripe !== 1'b0 || lane_cur !== 2'd0) begin
            errors++; $display("FAIL midrst_state: got v=%b l=%0d expected 0 0", valid_unstripe, lane_cur);
        end
        tick(1'b0, 4'b1111, 32'hB3B2B1B0, 1'b1);
        tick(1'b0, 4'b0000, '0, 1'b1);
        checks++;
        if (valid_unstripe !== 1'b1 || data_unstripe !== 8'hB0 || lane_cur !== 2'd1) begin
            errors++;
            $display("FAIL midrst_restart: got v=%b d=%h l=%0d expected 1 b0 1",
                     valid_unstripe, data_unstripe, lane_cur);
        end
        $display("reset midstream: first byte after release=%h", data_unstripe);
        for (int c = 0; c < 6; c++) tick(1'b0, 4'b0000, '0, 1'b1);
    endtask

    task automatic test_random();
        logic r, ru;
        int   bad;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 149) == 0);
            ru = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            tick(r, LANES'($urandom), rand_data(), ru);
            checks++;
            if (obs_ready !== m_ready_pre || valid_unstripe !== m_valid || data_unstripe !== m_data ||
                lane_cur !== LW'(m_lane) || int'(drop_count) !== m_drop) begin
                errors++; bad++;
                $display("FAIL random_cycle_%0d: got rdy=%b v=%b d=%h l=%0d drop=%0d expected rdy=%b v=%b d=%h l=%0d drop=%0d",
                         c, obs_ready, valid_unstripe, data_unstripe, lane_cur, drop_count,
                         m_ready_pre, m_valid, m_data, m_lane, m_drop);
            end
        end
        $display("test_random: 600 cycles, %0d mismatching", bad);
    endtask

    initial begin
        rst = 1'b1; valid_stripe = '0; data_stripe = '0; ready_unstripe = 1'b0;
        test_reset();
        test_ordered_merge();
        test_skew();
        test_backpressure_overflow();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_unstriping_n.md
Name: byte_unstriping_n

Overview:
- Parametrised successor to the two-lane byte unstriper. It merges LANES striped input lanes into one serial output stream, in strict round-robin lane order (lane 0, 1, …, LANES-1, 0, …).
- Runs on a single clock. Each lane has its own FIFO to absorb lane skew and rate mismatch, and the output side has ready/valid backpressure.
- Sits between the per-lane receive logic and the demux/serial output stage.

Parameters:
- LANES, 4, number of input lanes (>=1).
- WIDTH, 8, data width per lane and of the output.
- DEPTH, 4, entries per lane FIFO (power of 2, >=2).
- CNT_W, 8, width of the optional drop counter.

Ports:
- clk_8f  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- data_stripe  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- valid_stripe  in  LANES  per-lane write strobe.
- ready_stripe  out  LANES  lane i FIFO can accept a byte this cycle.
- data_unstripe  out  WIDTH  merged output byte (registered).
- valid_unstripe  out  1  data_unstripe holds a valid byte.
- ready_unstripe  in  1  downstream accepts the byte.
- lane_cur  out  clog2(LANES) (min 1)  lane index the next output byte will come from.
- drop_count  out  CNT_W  dropped-byte counter (optional feature).

Behaviour:
- Reset (rst=1 at an edge):
  - All FIFO counts and pointers go to 0; lane_cur=0.
  - data_unstripe=0, valid_unstripe=0, drop_count=0.
  - Overrides any simultaneous push or pop.
  - Mid-operation reset discards all buffered data; no partial round is resumed.
- ready_stripe[i]:
  - Combinational: equals (count_i < DEPTH) and !rst.
  - Conservative: a full FIFO deasserts ready even when a pop from that lane occurs in the same cycle.
- Push:
  - Happens when valid_stripe[i] and ready_stripe[i]. The byte is written at wptr_i, wptr_i wraps modulo DEPTH, and count_i increments.
  - If valid_stripe[i] is high while lane i is full, the byte is dropped and the FIFO is unchanged.
- Output register load:
  - Condition: out_free = !valid_unstripe or ready_unstripe, and FIFO[lane_cur] is non-empty.
  - On the edge: data_unstripe <= head of FIFO[lane_cur], valid_unstripe <= 1, that FIFO pops, and lane_cur <= (lane_cur==LANES-1) ? 0 : lane_cur+1.
- Output stall and drain:
  - If out_free holds but FIFO[lane_cur] is empty, the block stalls: lane_cur holds, and valid_unstripe <= 0 if the current byte was consumed.
  - Bytes from other lanes are never reordered ahead of the current lane.
  - If valid_unstripe=1 and ready_unstripe=0, data_unstripe, valid_unstripe and lane_cur all hold.
- Latency and throughput:
  - A byte pushed at edge k into an empty FIFO, when that lane is lane_cur and out_free holds, appears on data_unstripe after edge k+1.
  - Throughput is one byte per cycle while all lanes are fed.
- Simultaneous push and pop on the same non-full lane: count_i unchanged and both pointers advance. Data written this cycle is not bypassed to the output.
- LANES=1 degenerates to a DEPTH-entry FIFO with lane_cur fixed at 0.
- Count arithmetic is clog2(DEPTH)+1 bits, so no overflow.

Optional Feature:
- Macro: BYTE_UNSTRIPING_DROP_CNT_EN.
- Defined:
  - drop_count increments by the number of lanes with valid_stripe[i] & !ready_stripe[i] in that cycle.
  - It saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- Undefined: drop_count is tied to 0 and no counter logic is synthesised. Port list is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles while valid_stripe=4'b1111 → all outputs 0, ready_stripe=4'b1111 after release, lane_cur=0.
- Ordered merge: one cycle of lanes 0..3 = 0xA0, 0xA1, 0xA2, 0xA3, ready_unstripe=1 → data_unstripe = A0, A1, A2, A3 on four consecutive cycles starting one cycle after the push; lane_cur wraps 3→0.
- Skew: lane 2 delayed 3 cycles relative to the others → output shows A0, A1, then valid_unstripe=0 for the stall, then A2, A3. No reordering.
- Backpressure: ready_unstripe=0 for 5 cycles with continuous input → each lane accepts 4 bytes, then ready_stripe=4'b0000. Held data_unstripe is stable; on release the stream resumes with no loss.
- Overflow (macro on): 3 extra cycles of valid_stripe=4'b1111 while full → drop_count=12. With CNT_W=2 the counter stays at 3. With the macro off → drop_count=0.
- Reset mid-stream: rst asserted with 2 bytes buffered per lane → valid_unstripe=0 on the next cycle; new data after release starts at lane 0.
